atomrvcore_decode_stage: RTL
============================

ATOMRVCORE_DECODE_STAGE -- requirements
Module: atomrvcore_decode_stage

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, operand/immediate/register width.
REQ-002 SHALL have parameter REGISTERS, default 32, register count; legal values 16 (RV32E) or 32.
REQ-003 SHALL have parameter ALUOP_WIDTH, default 6, ALU opcode width.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all flops on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports in_valid_i/in_ready_o, in/out, 1 each, instruction handshake.
REQ-007 SHALL have port instr_i, input, 32, instruction word.
REQ-008 SHALL have ports wb_en_i (1), wb_rd_i (5) and wb_data_i (DATAWIDTH), inputs, register write-back port.
REQ-009 SHALL have port flush_i, input, 1, kills the held and incoming instruction.
REQ-010 SHALL have ports out_valid_o/out_ready_i, out/in, 1 each, issue handshake.
REQ-011 SHALL have ports op_a_o, op_b_o and imm_o, outputs, DATAWIDTH each; op_b_o carries rs2 for R/SB formats and imm for all others.
REQ-012 SHALL have ports rd_o (5), aluop_o (ALUOP_WIDTH) and fmt_o (6, one-hot I,R,S,SB,U,UJ), outputs.
REQ-013 SHALL have ports rd_we_o, mem_rd_o, mem_wr_o, jal_o, jalr_o, lui_o, auipc_o and illegal_o, outputs, 1 each.

Function
REQ-014 SHALL decode formats by opcode: I=0000011/0010011/1100111/1110011; R=0110011; S=0100011; SB=1100011; U=0110111 (LUI) or 0010111 (AUIPC); UJ=1101111.
REQ-015 SHALL sign-extend immediates per RV32I: I {20{b31},b31:20}; S {20{b31},b31:25,b11:7}; SB {19{b31},b31,b7,b30:25,b11:8,0}; U {b31:12,12'b0}; UJ {11{b31},b31,b19:12,b20,b30:21,0}.
REQ-016 SHALL use aluop encoding add=1, sll=2, slt=3, sltu=4, xor=5, srl=6, sra=7, or=8, and=9, sub=10, beq=11, bne=12, blt=13, bge=14, bltu=15, bgeu=16, jal=17, and 0 for loads, stores, LUI, AUIPC, JALR and SYSTEM.
REQ-017 SHALL set rd_we_o for R, I, U and UJ formats only, and force it to 0 when rd=0.
REQ-018 SHALL set illegal_o for an unlisted opcode, an undefined funct3/funct7 combination, or any rs1/rs2/rd index >= REGISTERS; an illegal instruction issues with rd_we_o, mem_rd_o and mem_wr_o all 0.
REQ-019 SHALL keep a REGISTERS x DATAWIDTH register file; x0 reads 0 and writes to it are ignored.
REQ-020 SHALL bypass a same-cycle write-back whose wb_rd_i matches rs1/rs2 (nonzero), giving wb_data_i to the operand read.
REQ-021 SHALL register all decode outputs in one output stage, so an accepted instruction appears 1 cycle after acceptance.
REQ-022 SHALL compute in_ready_o = !flush_i && !hazard && (!out_valid_o || out_ready_i).
REQ-023 SHALL detect a load-use hazard when out_valid_o && mem_rd_o && rd_o!=0 and rd_o equals a used rs1 (R/I/S/SB) or a used rs2 (R/S/SB) of a valid instr_i.
REQ-024 SHALL, under a hazard with out_ready_i=1, load a bubble (out_valid_o=0) and accept the instruction on the following cycle.
REQ-025 SHALL hold every output stable while out_valid_o=1 and out_ready_i=0.
REQ-026 SHALL, on flush_i, clear out_valid_o at the next edge, accept nothing that cycle, and give flush_i priority over all handshakes.
REQ-027 SHALL accept a new instruction in the same cycle the held one issues (back-to-back at 1 instruction/cycle).

Reset
REQ-028 SHALL, while rst_i=1, clear out_valid_o and all register-file entries and drive every other output to 0, taking effect asynchronously.
REQ-029 SHALL drop any held instruction on reset mid-operation, leaving no partial issue; in_ready_o=1 on the first cycle after release.

Verification
REQ-030 SHALL cover ADDI x1,x0,-5 (0xFFB00093) -> one cycle later out_valid_o=1, imm_o=0xFFFFFFFB, aluop_o=1, rd_o=1, rd_we_o=1, fmt_o=I.
REQ-031 SHALL cover wb x2=0x1234 in the same cycle as ADD x3,x2,x2 -> op_a_o=op_b_o=0x1234 (bypass).
REQ-032 SHALL cover LW x5,0(x1) followed by ADD x6,x5,x5 -> in_ready_o=0 for 1 cycle, one bubble, then ADD issues.
REQ-033 SHALL cover out_ready_i=0 for 3 cycles with in_valid_i=1 -> outputs stable, in_ready_o=0, no instruction lost or duplicated.
REQ-034 SHALL cover REGISTERS=16 with ADD x20,x1,x2 -> illegal_o=1, rd_we_o=0; plus flush_i with a held instruction -> out_valid_o=0 next cycle.
REQ-035 SHALL cover rst_i asserted mid-stream -> all outputs 0 immediately, x1 reads 0 after release.

Source files
------------

// File: rtl/atomrvcore_decode_stage.sv
// RV32I/RV32E decode stage: register file with write-back bypass, load-use
// hazard detection and a single registered issue slot with valid/ready handshakes.
module atomrvcore_decode_stage #(
    parameter int DATAWIDTH   = 32,
    parameter int REGISTERS   = 32,
    parameter int ALUOP_WIDTH = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [31:0]            instr_i,
    input  logic                   wb_en_i,
    input  logic [4:0]             wb_rd_i,
    input  logic [DATAWIDTH-1:0]   wb_data_i,
    input  logic                   flush_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATAWIDTH-1:0]   op_a_o,
    output logic [DATAWIDTH-1:0]   op_b_o,
    output logic [DATAWIDTH-1:0]   imm_o,
    output logic [4:0]             rd_o,
    output logic [ALUOP_WIDTH-1:0] aluop_o,
    output logic [5:0]             fmt_o,
    output logic                   rd_we_o,
    output logic                   mem_rd_o,
    output logic                   mem_wr_o,
    output logic                   jal_o,
    output logic                   jalr_o,
    output logic                   lui_o,
    output logic                   auipc_o,
    output logic                   illegal_o
);

    localparam int AW = $clog2(REGISTERS);
    localparam logic [5:0] REG_LIMIT = 6'(REGISTERS);

    localparam logic [5:0] FMT_I  = 6'b000001;
    localparam logic [5:0] FMT_R  = 6'b000010;
    localparam logic [5:0] FMT_S  = 6'b000100;
    localparam logic [5:0] FMT_SB = 6'b001000;
    localparam logic [5:0] FMT_U  = 6'b010000;
    localparam logic [5:0] FMT_UJ = 6'b100000;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_SYSTEM = 7'b1110011
    } opcode_e;

    typedef enum logic [4:0] {
        ALU_NONE = 5'd0,  ALU_ADD  = 5'd1,  ALU_SLL  = 5'd2,  ALU_SLT  = 5'd3,
        ALU_SLTU = 5'd4,  ALU_XOR  = 5'd5,  ALU_SRL  = 5'd6,  ALU_SRA  = 5'd7,
        ALU_OR   = 5'd8,  ALU_AND  = 5'd9,  ALU_SUB  = 5'd10, ALU_BEQ  = 5'd11,
        ALU_BNE  = 5'd12, ALU_BLT  = 5'd13, ALU_BGE  = 5'd14, ALU_BLTU = 5'd15,
        ALU_BGEU = 5'd16, ALU_JAL  = 5'd17
    } alu_e;

    function automatic logic reg_ok(input logic [4:0] idx);
        return {1'b0, idx} < REG_LIMIT;
    endfunction

    logic [DATAWIDTH-1:0] rf_q [REGISTERS];
    logic [DATAWIDTH-1:0] rf_d [REGISTERS];

    logic                   out_valid_q, out_valid_d;
    logic [DATAWIDTH-1:0]   op_a_q, op_a_d, op_b_q, op_b_d, imm_q, imm_d;
    logic [4:0]             rd_q, rd_d;
    logic [ALUOP_WIDTH-1:0] aluop_q, aluop_d;
    logic [5:0]             fmt_q, fmt_d;
    logic rd_we_q, rd_we_d, mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
    logic jal_q, jal_d, jalr_q, jalr_d, lui_q, lui_d, auipc_q, auipc_d;
    logic illegal_q, illegal_d;

    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [5:0]  fmt;
    alu_e        alu;
    logic [31:0] imm32;
    logic        bad_func, is_load, is_store, is_jal, is_jalr, is_lui, is_auipc;
    logic        use_rs1, use_rs2, has_rd, illegal;
    logic [DATAWIDTH-1:0] imm_ext, rs1_val, rs2_val;
    logic        hazard, accept;

    assign rs1 = instr_i[19:15];
    assign rs2 = instr_i[24:20];
    assign rd  = instr_i[11:7];
    assign f3  = instr_i[14:12];
    assign f7  = instr_i[31:25];

    always_comb begin
        fmt      = '0;
        alu      = ALU_NONE;
        imm32    = '0;
        bad_func = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        is_jal   = 1'b0;
        is_jalr  = 1'b0;
        is_lui   = 1'b0;
        is_auipc = 1'b0;
        case (instr_i[6:0])
            OP_LOAD: begin
                fmt      = FMT_I;
                imm32    = {{20{instr_i[31]}}, instr_i[31:20]};
                is_load  = 1'b1;
                bad_func = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OP_IMM: begin
                fmt   = FMT_I;
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
                case (f3)
                    3'b000: alu = ALU_ADD;
                    3'b001: begin
                        alu      = ALU_SLL;
                        bad_func = (f7 != 7'b0000000);
                    end
                    3'b010: alu = ALU_SLT;
                    3'b011: alu = ALU_SLTU;
                    3'b100: alu = ALU_XOR;
                    3'b101: begin
                        if (f7 == 7'b0000000)      alu = ALU_SRL;
                        else if (f7 == 7'b0100000) alu = ALU_SRA;
                        else                       bad_func = 1'b1;
                    end
                    3'b110: alu = ALU_OR;
                    default: alu = ALU_AND;
                endcase
            end
            OP_JALR: begin
                fmt      = FMT_I;
                imm32    = {{20{instr_i[31]}}, instr_i[31:20]};
                is_jalr  = 1'b1;
                bad_func = (f3 != 3'b000);
            end
            OP_SYSTEM: begin
                fmt      = FMT_I;
                imm32    = {{20{instr_i[31]}}, instr_i[31:20]};
                bad_func = (f3 == 3'b100);
            end
            OP_REG: begin
                fmt = FMT_R;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000: alu = ALU_ADD;
                        3'b001: alu = ALU_SLL;
                        3'b010: alu = ALU_SLT;
                        3'b011: alu = ALU_SLTU;
                        3'b100: alu = ALU_XOR;
                        3'b101: alu = ALU_SRL;
                        3'b110: alu = ALU_OR;
                        default: alu = ALU_AND;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    alu = ALU_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    alu = ALU_SRA;
                end else begin
                    bad_func = 1'b1;
                end
            end
            OP_STORE: begin
                fmt      = FMT_S;
                imm32    = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
                is_store = 1'b1;
                bad_func = f3[2] || (f3 == 3'b011);
            end
            OP_BRANCH: begin
                fmt   = FMT_SB;
                imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
                case (f3)
                    3'b000: alu = ALU_BEQ;
                    3'b001: alu = ALU_BNE;
                    3'b100: alu = ALU_BLT;
                    3'b101: alu = ALU_BGE;
                    3'b110: alu = ALU_BLTU;
                    3'b111: alu = ALU_BGEU;
                    default: bad_func = 1'b1;
                endcase
            end
            OP_LUI: begin
                fmt    = FMT_U;
                imm32  = {instr_i[31:12], 12'b0};
                is_lui = 1'b1;
            end
            OP_AUIPC: begin
                fmt      = FMT_U;
                imm32    = {instr_i[31:12], 12'b0};
                is_auipc = 1'b1;
            end
            OP_JAL: begin
                fmt    = FMT_UJ;
                imm32  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                          instr_i[20], instr_i[30:21], 1'b0};
                alu    = ALU_JAL;
                is_jal = 1'b1;
            end
            default: bad_func = 1'b1;
        endcase
    end

    assign use_rs1 = |(fmt & (FMT_I | FMT_R | FMT_S | FMT_SB));
    assign use_rs2 = |(fmt & (FMT_R | FMT_S | FMT_SB));
    assign has_rd  = |(fmt & (FMT_I | FMT_R | FMT_U | FMT_UJ));
    assign illegal = bad_func || (use_rs1 && !reg_ok(rs1)) ||
                     (use_rs2 && !reg_ok(rs2)) || (has_rd && !reg_ok(rd));
    assign imm_ext = DATAWIDTH'($signed(imm32));

    // Reads see this cycle's write-back so no extra forwarding is needed downstream.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != 5'd0 && reg_ok(rs1)) begin
            rs1_val = (wb_en_i && wb_rd_i == rs1) ? wb_data_i : rf_q[rs1[AW-1:0]];
        end
        if (rs2 != 5'd0 && reg_ok(rs2)) begin
            rs2_val = (wb_en_i && wb_rd_i == rs2) ? wb_data_i : rf_q[rs2[AW-1:0]];
        end
    end

    always_comb begin
        rf_d = rf_q;
        if (wb_en_i && wb_rd_i != 5'd0 && reg_ok(wb_rd_i)) begin
            rf_d[wb_rd_i[AW-1:0]] = wb_data_i;
        end
    end

    assign hazard = in_valid_i && out_valid_q && mem_rd_q && (rd_q != 5'd0) &&
                    ((use_rs1 && rs1 == rd_q) || (use_rs2 && rs2 == rd_q));
    assign in_ready_o = !rst_i && !flush_i && !hazard && (!out_valid_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        out_valid_d = out_valid_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        imm_d       = imm_q;
        rd_d        = rd_q;
        aluop_d     = aluop_q;
        fmt_d       = fmt_q;
        rd_we_d     = rd_we_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        jal_d       = jal_q;
        jalr_d      = jalr_q;
        lui_d       = lui_q;
        auipc_d     = auipc_q;
        illegal_d   = illegal_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            op_a_d      = rs1_val;
            op_b_d      = (fmt == FMT_R || fmt == FMT_SB) ? rs2_val : imm_ext;
            imm_d       = imm_ext;
            rd_d        = has_rd ? rd : 5'd0;
            aluop_d     = ALUOP_WIDTH'(alu);
            fmt_d       = fmt;
            rd_we_d     = has_rd && (rd != 5'd0) && !illegal;
            mem_rd_d    = is_load && !illegal;
            mem_wr_d    = is_store && !illegal;
            jal_d       = is_jal;
            jalr_d      = is_jalr;
            lui_d       = is_lui;
            auipc_d     = is_auipc;
            illegal_d   = illegal;
        end else if (out_ready_i) begin
            // Issued with nothing new accepted (or hazard bubble): slot empties.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rf_q        <= '{default: '0};
            out_valid_q <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            imm_q       <= '0;
            rd_q        <= '0;
            aluop_q     <= '0;
            fmt_q       <= '0;
            rd_we_q     <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            jal_q       <= 1'b0;
            jalr_q      <= 1'b0;
            lui_q       <= 1'b0;
            auipc_q     <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            rf_q        <= rf_d;
            out_valid_q <= out_valid_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            imm_q       <= imm_d;
            rd_q        <= rd_d;
            aluop_q     <= aluop_d;
            fmt_q       <= fmt_d;
            rd_we_q     <= rd_we_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            jal_q       <= jal_d;
            jalr_q      <= jalr_d;
            lui_q       <= lui_d;
            auipc_q     <= auipc_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign op_a_o      = op_a_q;
    assign op_b_o      = op_b_q;
    assign imm_o       = imm_q;
    assign rd_o        = rd_q;
    assign aluop_o     = aluop_q;
    assign fmt_o       = fmt_q;
    assign rd_we_o     = rd_we_q;
    assign mem_rd_o    = mem_rd_q;
    assign mem_wr_o    = mem_wr_q;
    assign jal_o       = jal_q;
    assign jalr_o      = jalr_q;
    assign lui_o       = lui_q;
    assign auipc_o     = auipc_q;
    assign illegal_o   = illegal_q;

endmodule
